popcount_neuron_acc: RTL and testbench
======================================

POPCOUNT_NEURON_ACC -- requirements
Module: popcount_neuron_acc

Interface
REQ-001 Parameter NUM_BEATS, default 4: number of popcount beats accumulated per neuron result; legal range 2..255.
REQ-002 Parameter ACC_W, default 8: signed accumulator and out_sum width; legal range 4..16.
REQ-003 Parameter THR_HI, default 3: signed upper threshold; sum >= THR_HI gives activation +1.
REQ-004 Parameter THR_LO, default -3: signed lower threshold; sum <= THR_LO gives activation -1; THR_LO < THR_HI is required.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_pos  input  3  unsigned popcount of +1-weighted inputs (approximate popcount stage output, full range 0..7).
REQ-010 in_neg  input  3  unsigned popcount of -1-weighted inputs (full range 0..7).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_act  output  2  ternary activation: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; 2'b10 never driven.
REQ-014 out_sum  output  ACC_W  signed, saturated accumulated sum for the completed neuron.

Function
REQ-015 Beat accepted on any cycle with in_valid && in_ready; no other cycle alters the accumulator.
REQ-016 FSM states: ACCUM, OUTPUT; reset state is ACCUM.
REQ-017 ACCUM: in_ready = 1, out_valid = 0; a beat counter (0..NUM_BEATS-1) increments per accepted beat.
REQ-018 Per accepted beat: acc <= sat(acc + in_pos - in_neg), with the delta computed as signed 4-bit (-7..+7) and sign-extended.
REQ-019 sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation is applied per beat, and a saturated acc continues to accumulate from the clamped value.
REQ-020 On acceptance of beat NUM_BEATS-1: the final saturated sum is registered into out_sum, out_act is computed from it, the FSM moves to OUTPUT, the counter clears to 0, and acc clears to 0.
REQ-021 Latency: out_valid is asserted on the cycle immediately after the last beat is accepted.
REQ-022 out_act = 01 if out_sum >= THR_HI; 11 if out_sum <= THR_LO; otherwise 00 (signed compares).
REQ-023 OUTPUT: out_valid = 1, in_ready = 0; out_sum and out_act are held stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready the FSM returns to ACCUM; in_ready rises in the next cycle; there is no bypass, so at least one bubble cycle follows each result.
REQ-025 out_valid, once asserted, does not drop without a handshake.
REQ-026 in_pos/in_neg are ignored when in_valid = 0 or in_ready = 0.
REQ-027 out_ready is ignored in ACCUM.

Reset
REQ-028 While rst_n = 0 at a clock edge: state = ACCUM, acc = 0, counter = 0, out_valid = 0, out_sum = 0, out_act = 00; in_ready reads 1 from the first cycle after reset.
REQ-029 Reset asserted mid-accumulation or in OUTPUT discards all partial and pending results; no result is emitted for the interrupted neuron.
REQ-030 Reset has priority over any simultaneous handshake.

Verification
REQ-031 Defaults; beats (pos,neg) = (4,0),(3,1),(2,0),(1,0) back-to-back, out_ready = 1 -> one cycle after the 4th beat: out_valid = 1, out_sum = 9, out_act = 01.
REQ-032 Defaults; beats (0,4),(1,3),(0,0),(2,2) -> out_sum = -6, out_act = 11; next neuron (1,0),(0,1),(2,0),(0,0) -> out_sum = 2, out_act = 00, with a bubble cycle between neurons.
REQ-033 NUM_BEATS = 8, ACC_W = 5; eight beats of (7,0) -> out_sum = 15 (saturated), out_act = 01; then eight beats of (0,7) -> out_sum = -16.
REQ-034 Defaults; out_ready held 0 for 10 cycles after a result -> out_valid stays 1, out_sum and out_act stay constant, in_ready = 0, and in_valid pulses during the stall are not counted.
REQ-035 Defaults; reset pulsed after 2 beats of (7,0), then 4 beats of (0,0) -> a single result with out_sum = 0 and out_act = 00.
REQ-036 Random in_valid gaps, thresholds at boundary (sum = 3 gives 01, sum = -3 gives 11, sum = 2 gives 00) -> matches a reference model, with exactly one result per NUM_BEATS accepted beats.

Source files
------------

// File: rtl/popcount_neuron_acc.sv
// popcount_neuron_acc: accumulates signed popcount deltas per neuron and emits a saturated sum with ternary activation
module popcount_neuron_acc #(
  parameter int NUM_BEATS = 4,
  parameter int ACC_W = 8,
  parameter int THR_HI = 3,
  parameter int THR_LO = -3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_pos,
  input  logic [2:0]              in_neg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum
);
  typedef enum logic {ACCUM, OUTPUT} state_t;
  localparam logic signed [ACC_W:0] max_v = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] min_v = -max_v - 1;
  state_t state;
  logic [7:0] cnt;
  logic signed [ACC_W-1:0] acc, next_acc;
  logic signed [3:0] delta;
  logic signed [ACC_W:0] raw;
  logic signed [31:0] next_ext;
  logic [1:0] next_act;
  assign in_ready = state == ACCUM;
  assign out_valid = state == OUTPUT;
  // one extra bit of headroom lets the clamp see overflow before truncation
  always_comb begin
    delta = signed'({1'b0, in_pos}) - signed'({1'b0, in_neg});
    raw = (ACC_W+1)'(acc) + (ACC_W+1)'(delta);
    next_acc = raw > max_v ? ACC_W'(max_v) : raw < min_v ? ACC_W'(min_v) : ACC_W'(raw);
    next_ext = 32'(next_acc);
    next_act = next_ext >= THR_HI ? 2'b01 : next_ext <= THR_LO ? 2'b11 : 2'b00;
  end
  // beat accumulation, result capture and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt <= '0;
      acc <= '0;
      out_sum <= '0;
      out_act <= 2'b00;
    end else if (state == ACCUM && in_valid) begin
      if (cnt == 8'(NUM_BEATS - 1)) begin
        out_sum <= next_acc;
        out_act <= next_act;
        state <= OUTPUT;
        cnt <= '0;
        acc <= '0;
      end else begin
        acc <= next_acc;
        cnt <= cnt + 8'd1;
      end
    end else if (state == OUTPUT && out_ready) begin
      state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_popcount_neuron_acc.sv
// tb_popcount_neuron_acc: directed checks of the default and a narrow saturating configuration
module tb_popcount_neuron_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic va, ra, vao, roa;
  logic [2:0] pa, na;
  logic [1:0] acta;
  logic signed [7:0] suma;
  logic vb, rb, vbo, rob;
  logic [2:0] pb, nb;
  logic [1:0] actb;
  logic signed [4:0] sumb;
  int checks = 0;
  int errors = 0;

  popcount_neuron_acc dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .in_pos(pa), .in_neg(na),
    .out_valid(vao), .out_ready(roa), .out_act(acta), .out_sum(suma)
  );

  popcount_neuron_acc #(.NUM_BEATS(8), .ACC_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .in_pos(pb), .in_neg(nb),
    .out_valid(vbo), .out_ready(rob), .out_act(actb), .out_sum(sumb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neuron_a(input string tag, input int p[4], input int n[4], input int gaps,
                          input int es, input int ea);
    for (int i = 0; i < 4; i++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) tick();
      va = 1'b1;
      pa = 3'(p[i]);
      na = 3'(n[i]);
      tick();
      va = 1'b0;
      if (i < 3) check({tag, "_early_v"}, 32'(vao), 0);
    end
    check({tag, "_v"}, 32'(vao), 1);
    check({tag, "_rdy"}, 32'(ra), 0);
    check({tag, "_sum"}, 32'(suma), es);
    check({tag, "_act"}, 32'(acta), ea);
  endtask

  task automatic neuron_b(input string tag, input int p[8], input int n[8], input int es, input int ea);
    for (int i = 0; i < 8; i++) begin
      vb = 1'b1;
      pb = 3'(p[i]);
      nb = 3'(n[i]);
      tick();
      vb = 1'b0;
      if (i < 7) check({tag, "_early_v"}, 32'(vbo), 0);
    end
    check({tag, "_v"}, 32'(vbo), 1);
    check({tag, "_sum"}, 32'(sumb), es);
    check({tag, "_act"}, 32'(actb), ea);
  endtask

  initial begin
    va = 0; pa = 0; na = 0; roa = 1;
    vb = 0; pb = 0; nb = 0; rob = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_va", 32'(vao), 0);
    check("rst_suma", 32'(suma), 0);
    check("rst_acta", 32'(acta), 0);
    check("rst_vb", 32'(vbo), 0);
    rst_n = 1'b1;
    tick();
    check("rst_rdy", 32'(ra), 1);

    neuron_a("n9", '{4, 3, 2, 1}, '{0, 1, 0, 0}, 0, 9, 1);
    tick();
    check("bubble_v", 32'(vao), 0);
    check("bubble_rdy", 32'(ra), 1);

    neuron_a("nm6", '{0, 1, 0, 2}, '{4, 3, 0, 2}, 0, -6, 3);
    tick();
    neuron_a("n2", '{1, 0, 2, 0}, '{0, 1, 0, 0}, 0, 2, 0);
    tick();

    roa = 1'b0;
    neuron_a("thr3", '{1, 1, 1, 0}, '{0, 0, 0, 0}, 0, 3, 1);
    for (int i = 0; i < 10; i++) begin
      va = 1'b1;
      pa = 3'd7;
      na = 3'd0;
      tick();
      check("stall_v", 32'(vao), 1);
      check("stall_rdy", 32'(ra), 0);
      check("stall_sum", 32'(suma), 3);
      check("stall_act", 32'(acta), 1);
    end
    va = 1'b0;
    roa = 1'b1;
    tick();
    check("release_v", 32'(vao), 0);
    neuron_a("thrm3", '{0, 0, 0, 0}, '{1, 1, 1, 0}, 0, -3, 3);
    tick();
    neuron_a("thrm2", '{0, 0, 0, 0}, '{1, 1, 0, 0}, 0, -2, 0);
    tick();

    va = 1'b1; pa = 3'd7; na = 3'd0;
    tick();
    tick();
    va = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_v", 32'(vao), 0);
    check("midrst_rdy", 32'(ra), 1);
    neuron_a("after_rst", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 0);
    tick();

    roa = 1'b0;
    neuron_a("pend", '{2, 2, 2, 2}, '{0, 0, 0, 0}, 0, 8, 1);
    rst_n = 1'b0;
    roa = 1'b1;
    va = 1'b1; pa = 3'd7;
    tick();
    rst_n = 1'b1;
    va = 1'b0;
    check("outrst_v", 32'(vao), 0);
    check("outrst_sum", 32'(suma), 0);
    check("outrst_act", 32'(acta), 0);
    neuron_a("post_outrst", '{1, 0, 0, 0}, '{0, 0, 0, 0}, 0, 1, 0);
    tick();

    neuron_a("gap3", '{3, 0, 0, 0}, '{0, 0, 0, 0}, 3, 3, 1);
    tick();
    neuron_a("gapm3", '{0, 1, 2, 0}, '{1, 1, 3, 1}, 3, -3, 3);
    tick();
    neuron_a("gap2", '{7, 0, 5, 2}, '{0, 7, 1, 4}, 3, 2, 0);
    tick();

    neuron_b("satp", '{7, 7, 7, 7, 7, 7, 7, 7}, '{0, 0, 0, 0, 0, 0, 0, 0}, 15, 1);
    tick();
    neuron_b("satn", '{0, 0, 0, 0, 0, 0, 0, 0}, '{7, 7, 7, 7, 7, 7, 7, 7}, -16, 3);
    tick();
    neuron_b("satrec", '{7, 7, 7, 0, 0, 0, 0, 0}, '{0, 0, 0, 7, 0, 0, 0, 0}, 8, 1);
    tick();
    check("b_done_v", 32'(vbo), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
